// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forward-select codes and pending-flush state type
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_MIS = 2'd1,
    PEND_EXC = 2'd2
  } pend_state_t;

endpackage

// File: rtl/hazard_unit_pl_if.sv
// rtl/hazard_unit_pl_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_pl_if #(
  parameter int REG_AW = 5,
  parameter int CP0_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
  logic [REG_AW-1:0] writeregE, writeregM, writeregW;
  logic              regwriteE, regwriteM, regwriteW;
  logic              memtoregE, memtoregM;
  logic              branchD, jumprD;
  logic [CP0_AW-1:0] cp0rdE, cp0rdM;
  logic              cp0writeM;
  logic              exc_req, mispredE;
  logic              i_stall, d_stall, div_stall;
  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD, forwardcp0E;
  logic              stallF, stallD, stallE, stallM, stallW;
  logic              flushF, flushD, flushE, flushM, flushW;
  logic              longest_stall;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jumprD, cp0rdE, cp0rdM, cp0writeM, exc_req, mispredE,
           i_stall, d_stall, div_stall,
    input  forwardAE, forwardBE, forwardAD, forwardBD, forwardcp0E,
           stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW, longest_stall, stall_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jumprD, cp0rdE, cp0rdM, cp0writeM, exc_req, mispredE,
           i_stall, d_stall, div_stall,
    output forwardAE, forwardBE, forwardAD, forwardBD, forwardcp0E,
           stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW, longest_stall, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_pl_flush_pend.sv
// rtl/hazard_unit_pl_flush_pend.sv - holds an exception/mispredict seen during a
// long stall and replays it as a single flush on the first non-stalled cycle
module flush_pend (
  input  logic clk,
  input  logic resetn,
  input  logic ls,
  input  logic exc_req,
  input  logic mispredE,
  output logic exc_eff,
  output logic mis_eff
);
  import hazard_pkg::*;

  pend_state_t state_q, state_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // An exception always overrides a held mispredict; release happens on !ls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ls && exc_req)       state_d = PEND_EXC;
        else if (ls && mispredE) state_d = PEND_MIS;
      end
      PEND_MIS: begin
        if (exc_req)  state_d = PEND_EXC;
        else if (!ls) state_d = IDLE;
      end
      PEND_EXC: begin
        if (!ls) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign exc_eff = exc_req  | (state_q == PEND_EXC);
  assign mis_eff = mispredE | (state_q == PEND_MIS);

endmodule

// File: rtl/hazard_unit_pl.sv
// rtl/hazard_unit_pl.sv - 5-stage hazard unit: forwarding, stalls, flushes.
// Optional stall-cycle counter under HAZARD_PERF_EN.
module hazard_unit_pl #(
  parameter int REG_AW = 5,
  parameter int CP0_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           resetn,
  hazard_unit_pl_if.slave hz
);
  import hazard_pkg::*;

  localparam logic [REG_AW-1:0] R0 = '0;
  localparam logic [CP0_AW-1:0] C0 = '0;

  logic [1:0] fwd_a, fwd_b;
  logic       lwstall, ctlstall, ls, stall_d;
  logic       exc_eff, mis_eff;
  logic       e_hits_d, m_hits_d;

  always_comb begin
    fwd_a = FWD_REG;
    if (hz.rsE != R0 && hz.regwriteM && hz.writeregM == hz.rsE)      fwd_a = FWD_MEM;
    else if (hz.rsE != R0 && hz.regwriteW && hz.writeregW == hz.rsE) fwd_a = FWD_WB;
    fwd_b = FWD_REG;
    if (hz.rtE != R0 && hz.regwriteM && hz.writeregM == hz.rtE)      fwd_b = FWD_MEM;
    else if (hz.rtE != R0 && hz.regwriteW && hz.writeregW == hz.rtE) fwd_b = FWD_WB;
  end

  assign hz.forwardAE   = fwd_a;
  assign hz.forwardBE   = fwd_b;
  assign hz.forwardAD   = (hz.rsD != R0) && hz.regwriteM && (hz.writeregM == hz.rsD);
  assign hz.forwardBD   = (hz.rtD != R0) && hz.regwriteM && (hz.writeregM == hz.rtD);
  assign hz.forwardcp0E = hz.cp0writeM && (hz.cp0rdE != C0) && (hz.cp0rdE == hz.cp0rdM);

  assign lwstall  = hz.memtoregE && (hz.writeregE != R0) &&
                    ((hz.rsD == hz.writeregE) || (hz.rtD == hz.writeregE));
  assign e_hits_d = hz.regwriteE && (hz.writeregE != R0) &&
                    ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
  assign m_hits_d = hz.memtoregM && (hz.writeregM != R0) &&
                    ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
  assign ctlstall = (hz.branchD || hz.jumprD) && (e_hits_d || m_hits_d);
  assign ls       = hz.i_stall || hz.d_stall || hz.div_stall;

  flush_pend u_flush_pend (
    .clk      (clk),
    .resetn   (resetn),
    .ls       (ls),
    .exc_req  (hz.exc_req),
    .mispredE (hz.mispredE),
    .exc_eff  (exc_eff),
    .mis_eff  (mis_eff)
  );

  assign stall_d          = ls || lwstall || ctlstall;
  assign hz.stallD        = stall_d;
  assign hz.stallF        = stall_d && !exc_eff;
  assign hz.stallE        = ls;
  assign hz.stallM        = ls;
  assign hz.stallW        = ls;
  assign hz.longest_stall = ls;

  // Flushes are suppressed while any long stall holds the pipe.
  assign hz.flushF = 1'b0;
  assign hz.flushD = (mis_eff || exc_eff) && !ls;
  assign hz.flushE = (lwstall || ctlstall || exc_eff) && !ls;
  assign hz.flushM = exc_eff && !ls;
  assign hz.flushW = exc_eff && !ls;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cycles = stall_cnt_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_pl.sv
// tb/tb_hazard_unit_pl.sv - directed vectors with a queue-based scoreboard
module tb_hazard_unit_pl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_pl_if #(.REG_AW(5), .CP0_AW(5), .CNT_W(CW)) hif ();

  hazard_unit_pl #(.REG_AW(5), .CP0_AW(5), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hif.slave)
  );

  // fwd = {AE, BE, AD, BD, cp0}; stl/fl = {F, D, E, M, W}
  typedef struct packed {
    logic [6:0]    fwd;
    logic [4:0]    stl;
    logic [4:0]    fl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t    exp_q[$];
  string   name_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  logic [CW-1:0] model_cnt = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
    hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
    hif.memtoregE = 0; hif.memtoregM = 0; hif.branchD = 0; hif.jumprD = 0;
    hif.cp0rdE = '0; hif.cp0rdM = '0; hif.cp0writeM = 0;
    hif.exc_req = 0; hif.mispredE = 0;
    hif.i_stall = 0; hif.d_stall = 0; hif.div_stall = 0;
  endtask

  task automatic step(input string nm, input logic [6:0] fwd, input logic [4:0] stl,
                      input logic [4:0] fl);
    exp_t e;
    e.fwd = fwd; e.stl = stl; e.fl = fl;
`ifdef HAZARD_PERF_EN
    e.cnt = model_cnt;
    if (stl[3] && model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 1'b1;
`else
    e.cnt = '0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "fwd", {1'b0, hif.forwardAE, hif.forwardBE, hif.forwardAD,
                        hif.forwardBD, hif.forwardcp0E}, {1'b0, e.fwd});
        cmp(nm, "stall", {3'b0, hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW},
            {3'b0, e.stl});
        cmp(nm, "flush", {3'b0, hif.flushF, hif.flushD, hif.flushE, hif.flushM, hif.flushW},
            {3'b0, e.fl});
        cmp(nm, "ls", {7'b0, hif.longest_stall}, {7'b0, e.stl[2]});
        cmp(nm, "cnt", {{(8-CW){1'b0}}, hif.stall_cycles}, {{(8-CW){1'b0}}, e.cnt});
      end
    end
  end

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step("rst_idle", 7'b0, 5'b00000, 5'b00000);

    // forwarding
    tick(); clr(); hif.rsE = 5; hif.writeregM = 5; hif.regwriteM = 1;
    hif.writeregW = 5; hif.regwriteW = 1;
    step("fwd_m_over_w", {2'b10, 2'b00, 3'b000}, 5'b0, 5'b0);
    tick(); hif.writeregM = 3;
    step("fwd_w", {2'b01, 2'b00, 3'b000}, 5'b0, 5'b0);
    tick(); clr(); hif.rtE = 7; hif.rsD = 7; hif.rtD = 7; hif.writeregM = 7; hif.regwriteM = 1;
    step("fwd_bd", {2'b00, 2'b10, 3'b110}, 5'b0, 5'b0);
    tick(); clr(); hif.regwriteM = 1; hif.regwriteW = 1;
    step("fwd_r0", 7'b0, 5'b0, 5'b0);
    tick(); clr(); hif.cp0writeM = 1; hif.cp0rdE = 12; hif.cp0rdM = 12;
    step("cp0_hit", 7'b0000001, 5'b0, 5'b0);
    tick(); hif.cp0rdE = 0; hif.cp0rdM = 0;
    step("cp0_zero", 7'b0, 5'b0, 5'b0);

    // load-use and control stalls, immediate flushes
    tick(); clr(); hif.memtoregE = 1; hif.writeregE = 8; hif.rtD = 8;
    step("lwstall", 7'b0, 5'b11000, 5'b00100);
    tick(); hif.writeregE = 0;
    step("lw_r0", 7'b0, 5'b0, 5'b0);
    tick(); clr(); hif.branchD = 1; hif.regwriteE = 1; hif.writeregE = 4; hif.rsD = 4;
    step("ctl_e", 7'b0, 5'b11000, 5'b00100);
    tick(); clr(); hif.jumprD = 1; hif.memtoregM = 1; hif.writeregM = 9; hif.rtD = 9;
    step("ctl_m", 7'b0, 5'b11000, 5'b00100);
    tick(); clr(); hif.mispredE = 1;
    step("mis_now", 7'b0, 5'b0, 5'b01000);
    tick(); clr(); hif.exc_req = 1;
    step("exc_now", 7'b0, 5'b0, 5'b01111);

    // exception pulse held through a d_stall
    tick(); clr(); hif.d_stall = 1;
    step("t3_c1", 7'b0, 5'b11111, 5'b0);
    tick(); hif.exc_req = 1;
    step("t3_c2", 7'b0, 5'b01111, 5'b0);
    for (int i = 3; i <= 5; i++) begin
      tick(); hif.exc_req = 0;
      step("t3_hold", 7'b0, 5'b01111, 5'b0);
    end
    tick(); hif.d_stall = 0;
    step("t3_rel", 7'b0, 5'b0, 5'b01111);
    tick();
    step("t3_after", 7'b0, 5'b0, 5'b0);

    // mispredict then exception during one stall
    tick(); clr(); hif.i_stall = 1;
    step("t4_c0", 7'b0, 5'b11111, 5'b0);
    tick(); hif.mispredE = 1;
    step("t4_mis", 7'b0, 5'b11111, 5'b0);
    tick(); hif.mispredE = 0;
    step("t4_pm", 7'b0, 5'b11111, 5'b0);
    tick(); hif.exc_req = 1;
    step("t4_exc", 7'b0, 5'b01111, 5'b0);
    tick(); hif.exc_req = 0;
    step("t4_pe", 7'b0, 5'b01111, 5'b0);
    tick(); hif.i_stall = 0;
    step("t4_rel", 7'b0, 5'b0, 5'b01111);
    tick();
    step("t4_after", 7'b0, 5'b0, 5'b0);

    // new exception on the release cycle merges into the single flush
    tick(); clr(); hif.div_stall = 1;
    step("mg_c0", 7'b0, 5'b11111, 5'b0);
    tick(); hif.exc_req = 1;
    step("mg_exc", 7'b0, 5'b01111, 5'b0);
    tick(); hif.div_stall = 0; hif.exc_req = 1;
    step("mg_rel", 7'b0, 5'b0, 5'b01111);
    tick(); hif.exc_req = 0;
    step("mg_after", 7'b0, 5'b0, 5'b0);

    // reset while an exception is pending
    tick(); clr(); hif.d_stall = 1;
    step("t5_c0", 7'b0, 5'b11111, 5'b0);
    tick(); hif.exc_req = 1;
    step("t5_exc", 7'b0, 5'b01111, 5'b0);
    tick(); hif.exc_req = 0; resetn = 1'b0; model_cnt = '0;
    tick();
    tick(); resetn = 1'b1;
    step("t5_post", 7'b0, 5'b11111, 5'b0);
    tick(); hif.d_stall = 0;
    step("t5_rel", 7'b0, 5'b0, 5'b0);

    // counter saturation from a clean reset
    tick(); clr(); resetn = 1'b0; model_cnt = '0;
    tick(); resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      hif.d_stall = 1;
      step("t6_stall", 7'b0, 5'b11111, 5'b0);
    end
    tick(); hif.d_stall = 0;
    step("t6_hold", 7'b0, 5'b0, 5'b0);
    tick();
    step("t6_hold2", 7'b0, 5'b0, 5'b0);

    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
